axis_packet_fifo: RTL

//  Parametrised AXI4-Stream FIFO carrying the full sideband set (tdata/tstrb/tkeep/tlast/tid/tdest/tuser).

---
 rtl/axis_packet_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axis_packet_fifo.sv
// Synchronous AXI4-Stream FIFO carrying the full sideband set.
// Cut-through by default; with PACKET_MODE=1 a packet is only presented once
// its tlast beat is stored, unless it is too large to fit (cut_through).
module axis_packet_fifo #(
  parameter int TDATA_BYTES = 4,
  parameter int TID_BITS    = 4,
  parameter int TDEST_BITS  = 4,
  parameter int TUSER_BITS  = 4,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [8*TDATA_BYTES-1:0]  s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]    s_axis_tstrb,
  input  logic [TDATA_BYTES-1:0]    s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [TID_BITS-1:0]       s_axis_tid,
  input  logic [TDEST_BITS-1:0]     s_axis_tdest,
  input  logic [TUSER_BITS-1:0]     s_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [8*TDATA_BYTES-1:0]  m_axis_tdata,
  output logic [TDATA_BYTES-1:0]    m_axis_tstrb,
  output logic [TDATA_BYTES-1:0]    m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [TID_BITS-1:0]       m_axis_tid,
  output logic [TDEST_BITS-1:0]     m_axis_tdest,
  output logic [TUSER_BITS-1:0]     m_axis_tuser,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [$clog2(DEPTH):0]    pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // One stored beat: every field travels together so nothing can skew.
  typedef struct packed {
    logic [8*TDATA_BYTES-1:0] data;
    logic [TDATA_BYTES-1:0]   strb;
    logic [TDATA_BYTES-1:0]   keep;
    logic                     last;
    logic [TID_BITS-1:0]      id;
    logic [TDEST_BITS-1:0]    dest;
    logic [TUSER_BITS-1:0]    user;
  } beat_t;

  beat_t          mem_q [DEPTH];
  beat_t          head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic [LW-1:0]  pkt_q, pkt_d;
  logic           cut_q, cut_d;
  logic           full, empty, release_ok, push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Store-and-forward gate: hold the head until a whole packet is stored,
  // or until an oversize packet forces cut-through to avoid deadlock.
  assign release_ok = (PACKET_MODE == 0) || (pkt_q != '0) || cut_q;

  assign s_axis_tready = !full && !areset;
  assign m_axis_tvalid = !empty && release_ok && !areset;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata = head.data;
  assign m_axis_tstrb = head.strb;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tlast = head.last;
  assign m_axis_tid   = head.id;
  assign m_axis_tdest = head.dest;
  assign m_axis_tuser = head.user;

  assign fill_level = level_q;
  assign pkt_count  = pkt_q;

  // Next-state for occupancy, packet count and the cut-through flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q + LW'(push) - LW'(pop);
    pkt_d   = pkt_q + LW'(push && s_axis_tlast)
                    - LW'(pop && head.last && (pkt_q != '0));
    cut_d   = cut_q;
    if (PACKET_MODE != 0) begin
      if (pop && head.last)
        cut_d = 1'b0;
      else if (full && (pkt_q == '0))
        cut_d = 1'b1;
    end
  end

  // Control state: pointers, counters and cut-through flag.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      cut_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      pkt_q   <= pkt_d;
      cut_q   <= cut_d;
    end
  end

  // Payload storage written on every accepted beat.
  always_ff @(posedge aclk) begin
    // NOTE: the storage array is deliberately not reset; contents are only visible while tvalid is high.
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: s_axis_tdata, strb: s_axis_tstrb, keep: s_axis_tkeep,
                           last: s_axis_tlast, id: s_axis_tid, dest: s_axis_tdest,
                           user: s_axis_tuser};
    end
  end

endmodule
